pipe_ctrl: RTL and testbench

Central pipeline sequencing controller for the 5-stage MIPS core.
- Drives the load-enable and bubble-insert inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Inputs are per-stage stall requests, the MEM-stage exception/ERET event and the exception target registers.
- Owns the flush sequence and produces the redirect PC for the fetch unit.

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipe_ctrl_stall_encoder.sv | 36 +++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state
// encoding, pipeline register indices, exception vector default and the
// saturating increment used by the performance counters.
package pipe_pkg;

  // Controller FSM states
  typedef enum logic {
    PIPE_RUN   = 1'b0,
    PIPE_FLUSH = 1'b1
  } pipe_state_t;

  // Pipeline register indices as seen on en/bubble
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_WB    = 4;

  localparam int NUM_STAGES = 5;
  localparam int NUM_STALL  = 4;

  // Wide enough to hold FLUSH_CYCLES-1 for FLUSH_CYCLES up to 15
  localparam int FLUSH_CNT_W = 4;

  localparam logic [31:0] DEFAULT_VEC_OFFSET = 32'h0000_0180;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// Priority encoder from the four stage stall requests to pipeline register
// controls. The deepest stalling stage d freezes registers 0..d, the register
// just downstream of it takes a bubble, and everything further down flows.
// Stall request bit i belongs to the stage feeding register i+1
// (0=IF, 1=ID, 2=EX, 3=MEM).
module stall_encoder
  import pipe_pkg::*;
(
  input  logic [NUM_STALL-1:0]  stallreq,
  output logic [NUM_STAGES-1:0] en,
  output logic [NUM_STAGES-1:0] bubble
);

  // One extra zero bit on top so register 4 (MEM/WB) sees "no stall above"
  logic [NUM_STAGES-1:0] req_ext;
  logic [NUM_STAGES-1:0] stall_at_or_above;

  assign req_ext = {1'b0, stallreq};

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      // Register gi is frozen if its own stage or any deeper stage stalls
      assign stall_at_or_above[gi] = |req_ext[NUM_STAGES-1:gi];
      assign en[gi] = ~stall_at_or_above[gi];

      if (gi == STG_PC) begin : g_pc
        // Nothing upstream of the PC can insert a bubble into it
        assign bubble[gi] = 1'b0;
      end else begin : g_reg
        // Bubble lands right below the deepest stalling stage
        assign bubble[gi] = req_ext[gi-1] & ~stall_at_or_above[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencing controller for the 5-stage MIPS core.
// Generates load enables / bubble inserts for PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB, runs the exception/ERET flush sequence and supplies the fetch
// redirect target. All control outputs are combinational from inputs and
// state. Optional stall/flush performance counters are built only when
// PIPE_PERF_CNT_EN is defined; otherwise both counter outputs are tied to 0.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] VEC_OFFSET   = DEFAULT_VEC_OFFSET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic        excp_is_eret,
  input  logic [31:0] epc,
  input  logic [31:0] ebase,
  output logic [4:0]  en,
  output logic [4:0]  bubble,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        new_pc_valid,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // Remaining FLUSH-state cycles after the event cycle itself
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  pipe_state_t            state_reg;
  logic [FLUSH_CNT_W-1:0] flush_left_reg;

  logic [NUM_STALL-1:0]  stallreq;
  logic [NUM_STAGES-1:0] enc_en;
  logic [NUM_STAGES-1:0] enc_bubble;
  logic                  any_stall;
  logic                  event_accept;
  logic [31:0]           redirect_pc;

  assign stallreq  = {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if};
  assign any_stall = |stallreq;

  // A MEM-stage stall holds the excepting instruction back, so the event
  // waits until MEM is free; FLUSH masks it entirely.
  assign event_accept = (state_reg == PIPE_RUN) && excp_valid && !stallreq_mem;

  assign redirect_pc = excp_is_eret ? epc : (ebase + VEC_OFFSET);

  stall_encoder u_stall_encoder (
    .stallreq (stallreq),
    .en       (enc_en),
    .bubble   (enc_bubble)
  );

  // Flush sequencing FSM: an accepted event opens a FLUSH window that lasts
  // FLUSH_CYCLES-1 cycles beyond the event cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= PIPE_RUN;
      flush_left_reg <= '0;
    end else begin
      case (state_reg)
        PIPE_RUN: begin
          if (event_accept && (FLUSH_CYCLES > 1)) begin
            state_reg      <= PIPE_FLUSH;
            flush_left_reg <= FLUSH_LOAD;
          end
        end
        PIPE_FLUSH: begin
          if (flush_left_reg <= FLUSH_CNT_W'(1)) begin
            state_reg      <= PIPE_RUN;
            flush_left_reg <= '0;
          end else begin
            flush_left_reg <= flush_left_reg - FLUSH_CNT_W'(1);
          end
        end
        default: begin
          state_reg      <= PIPE_RUN;
          flush_left_reg <= '0;
        end
      endcase
    end
  end

  // Output decode: reset defaults, then FLUSH, then an accepted event, then
  // the stall priority encoding.
  always_comb begin
    en           = 5'b11111;
    bubble       = 5'b00000;
    flush        = 1'b0;
    new_pc       = 32'h0000_0000;
    new_pc_valid = 1'b0;
    if (rst) begin
      en = 5'b11111;
    end else if (state_reg == PIPE_FLUSH) begin
      // Let the PC run on from the redirect target while the rest drains
      flush       = 1'b1;
      en          = 5'b00000;
      en[STG_PC]  = 1'b1;
    end else if (event_accept) begin
      flush        = 1'b1;
      en           = 5'b00000;
      new_pc       = redirect_pc;
      new_pc_valid = 1'b1;
    end else begin
      en     = enc_en;
      bubble = enc_bubble;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // Saturating counters of stalled RUN cycles and accepted events
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if ((state_reg == PIPE_RUN) && any_stall && !event_accept) begin
        stall_cnt_reg <= sat_inc(stall_cnt_reg);
      end
      if (event_accept) begin
        flush_cnt_reg <= sat_inc(flush_cnt_reg);
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  // any_stall only feeds the counters; keep it referenced for the linter
  logic unused_any_stall;
  assign unused_any_stall = any_stall;

  assign stall_cnt = 32'h0000_0000;
  assign flush_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. Three instances (FLUSH_CYCLES = 1, 2, 4)
// share one input set; a behavioural model per instance predicts every output
// each cycle from the controller's rules. Directed steps follow the test plan,
// then a randomized run exercises mixed stalls, events and resets.
module tb_pipe_ctrl;

  localparam int NI = 3;
  localparam int FC_TAB [NI] = '{1, 2, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid, excp_is_eret;
  logic [31:0] epc, ebase;

  logic [4:0]  en_o        [NI];
  logic [4:0]  bubble_o    [NI];
  logic        flush_o     [NI];
  logic [31:0] new_pc_o    [NI];
  logic        npv_o       [NI];
  logic [31:0] stall_cnt_o [NI];
  logic [31:0] flush_cnt_o [NI];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      pipe_ctrl #(
        .FLUSH_CYCLES (FC_TAB[gi]),
        .VEC_OFFSET   (32'h0000_0180)
      ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excp_valid   (excp_valid),
        .excp_is_eret (excp_is_eret),
        .epc          (epc),
        .ebase        (ebase),
        .en           (en_o[gi]),
        .bubble       (bubble_o[gi]),
        .flush        (flush_o[gi]),
        .new_pc       (new_pc_o[gi]),
        .new_pc_valid (npv_o[gi]),
        .stall_cnt    (stall_cnt_o[gi]),
        .flush_cnt    (flush_cnt_o[gi])
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: flush cycles still owed after the current one, plus counters
  int          rem    [NI];
  logic [31:0] m_stall[NI];
  logic [31:0] m_flush[NI];

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d cyc %0d: got %h expected %h", tag, k, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // Check all instances mid-cycle, then advance the model on the clock edge
  task automatic run_cycle(input bit verbose);
    logic [3:0]  sr;
    logic [4:0]  e_en, e_bub;
    logic        e_fl, e_v;
    logic [31:0] e_pc;
    bit          accept;
    int          d;
    @(negedge clk);
    sr = {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if};
    for (int k = 0; k < NI; k++) begin
      e_en = 5'b11111; e_bub = 5'b0; e_fl = 1'b0; e_v = 1'b0; e_pc = 32'h0;
      accept = 1'b0;
      if (rst) begin
        e_en = 5'b11111;
      end else if (rem[k] > 0) begin
        e_en = 5'b00001; e_fl = 1'b1;
      end else if (excp_valid && !stallreq_mem) begin
        accept = 1'b1;
        e_en = 5'b00000; e_fl = 1'b1; e_v = 1'b1;
        e_pc = excp_is_eret ? epc : ebase + 32'h0000_0180;
      end else if (sr != 4'b0) begin
        d = 0;
        for (int s = 0; s < 4; s++) if (sr[s]) d = s;
        e_en  = 5'((5'b11111 << (d + 1)) & 5'b11111);
        e_bub = 5'(1 << (d + 1));
      end
      chk("en", k, 32'(en_o[k]), 32'(e_en));
      chk("bubble", k, 32'(bubble_o[k]), 32'(e_bub));
      chk("flush", k, 32'(flush_o[k]), 32'(e_fl));
      chk("new_pc_valid", k, 32'(npv_o[k]), 32'(e_v));
      if (e_v || rst) chk("new_pc", k, new_pc_o[k], e_pc);
`ifdef PIPE_PERF_CNT_EN
      chk("stall_cnt", k, stall_cnt_o[k], m_stall[k]);
      chk("flush_cnt", k, flush_cnt_o[k], m_flush[k]);
`else
      chk("stall_cnt", k, stall_cnt_o[k], 32'h0);
      chk("flush_cnt", k, flush_cnt_o[k], 32'h0);
`endif
      if (verbose && k == 1)
        $display("cyc %0d rst=%b sr=%b ev=%b eret=%b | fc2 en=%b bub=%b flush=%b npv=%b pc=%h",
                 cyc, rst, sr, excp_valid, excp_is_eret, en_o[k], bubble_o[k],
                 flush_o[k], npv_o[k], new_pc_o[k]);
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end else if (rem[k] > 0) begin
        rem[k]--;
      end else if (excp_valid && !stallreq_mem) begin
        rem[k] = FC_TAB[k] - 1;
        m_flush[k] = sat1(m_flush[k]);
      end else if (sr != 4'b0) begin
        m_stall[k] = sat1(m_stall[k]);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input logic r, input logic s_if, input logic s_id,
                       input logic s_ex, input logic s_mem, input logic ev,
                       input logic eret);
    rst = r; stallreq_if = s_if; stallreq_id = s_id; stallreq_ex = s_ex;
    stallreq_mem = s_mem; excp_valid = ev; excp_is_eret = eret;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
    epc = 32'h0; ebase = 32'h0;
    drive(1, 0, 0, 0, 0, 0, 0);
    // First edge only initialises the flops; nothing is known before it
    @(posedge clk); #1;
    run_cycle(1);                                         // reset defaults
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) run_cycle(1);                              // free running
    drive(0, 1, 1, 0, 0, 0, 0); run_cycle(1);             // IF+ID stall
    drive(0, 0, 0, 0, 0, 0, 0); run_cycle(1);
    drive(0, 0, 0, 1, 0, 0, 0); repeat (4) run_cycle(1);  // divider stall
    drive(0, 0, 0, 0, 0, 0, 0); run_cycle(1);
    ebase = 32'h8000_0000;                                // exception over EX stall
    drive(0, 0, 0, 1, 0, 1, 0); run_cycle(1);
    drive(0, 0, 0, 0, 0, 1, 0); run_cycle(1);             // re-asserted, masked in FLUSH
    drive(0, 0, 0, 0, 0, 0, 0); repeat (4) run_cycle(1);
    drive(0, 0, 0, 0, 1, 1, 0); repeat (3) run_cycle(1);  // event held off by MEM stall
    epc = 32'hBFC0_0100;
    drive(0, 0, 0, 0, 0, 1, 1); run_cycle(1);             // ERET accepted
    drive(0, 0, 0, 0, 0, 0, 0); repeat (4) run_cycle(1);
    drive(0, 1, 0, 0, 0, 1, 0); run_cycle(1);             // event, then reset mid-FLUSH
    drive(1, 0, 0, 0, 0, 0, 0); run_cycle(1);
    drive(0, 0, 0, 0, 0, 0, 0); repeat (3) run_cycle(1);

    for (int n = 0; n < 400; n++) begin
      epc   = $urandom;
      ebase = $urandom;
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 6) == 0), 1'($urandom_range(0, 1)));
      run_cycle(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
